// File: rtl/sobel_pkg.sv
// Shared constants, pixel type and FSM state encoding for the Sobel edge stage.
// Optional feature macro: SOBEL_THRESHOLD_EN (binarize output against THRESH).
package sobel_pkg;

  localparam int unsigned IMG_W  = 320;
  localparam int unsigned IMG_H  = 240;
  localparam int unsigned N      = IMG_W * IMG_H;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned THRESH = 128;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sobel_edge_detect_if.sv
// Start/status handshake plus gray-read and edge-write BRAM ports of the Sobel stage.
interface sobel_edge_detect_if;
  import sobel_pkg::*;

  logic              i_START;
  logic              o_BUSY;
  logic              o_DONE;
  logic [ADDR_W-1:0] o_GRAY_ADDR;
  logic              o_GRAY_RE;
  pixel_t            i_GRAY_DATA;
  logic [ADDR_W-1:0] o_EDGE_ADDR;
  pixel_t            o_EDGE_DATA;
  logic              o_EDGE_WE;

  // Sobel block side
  modport slave (
    input  i_START, i_GRAY_DATA,
    output o_BUSY, o_DONE, o_GRAY_ADDR, o_GRAY_RE, o_EDGE_ADDR, o_EDGE_DATA, o_EDGE_WE
  );

  // Controller / memory side
  modport master (
    output i_START, i_GRAY_DATA,
    input  o_BUSY, o_DONE, o_GRAY_ADDR, o_GRAY_RE, o_EDGE_ADDR, o_EDGE_DATA, o_EDGE_WE
  );

endinterface

// File: rtl/sobel_window.sv
// 3x3 raster window: two circular line buffers plus two registered columns.
// The newest column is the incoming pixel and the line-buffer taps, so the
// window is usable in the same cycle the pixel arrives.
module sobel_window
  import sobel_pkg::*;
#(
  parameter int unsigned W = IMG_W
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   shift_en,
  input  pixel_t pix_in,
  output pixel_t p00, output pixel_t p01, output pixel_t p02,
  output pixel_t p10, output pixel_t p11, output pixel_t p12,
  output pixel_t p20, output pixel_t p21, output pixel_t p22
);

  localparam int unsigned PW = $clog2(W);

  pixel_t          lb1_mem [W];
  pixel_t          lb2_mem [W];
  logic [PW-1:0]   ptr_q, ptr_d;
  pixel_t          tap1, tap2;
  pixel_t [2:0]    col0_q, col0_d, col1_q, col1_d;

  // Line-buffer taps, column shift and wrap-around pointer
  always_comb begin
    tap1   = lb1_mem[ptr_q];
    tap2   = lb2_mem[ptr_q];
    ptr_d  = ptr_q;
    col0_d = col0_q;
    col1_d = col1_q;
    if (shift_en) begin
      ptr_d  = (ptr_q == PW'(W - 1)) ? '0 : ptr_q + 1'b1;
      col1_d = {pix_in, tap1, tap2};
      col0_d = col1_q;
    end
  end

  // Line buffers: data only, no reset needed
  always_ff @(posedge clk) begin
    if (shift_en) begin
      lb1_mem[ptr_q] <= pix_in;
      lb2_mem[ptr_q] <= tap1;
    end
  end

  // Window column registers and buffer pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      col0_q <= '0;
      col1_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      col0_q <= col0_d;
      col1_q <= col1_d;
    end
  end

  assign p00 = col0_q[0];
  assign p10 = col0_q[1];
  assign p20 = col0_q[2];
  assign p01 = col1_q[0];
  assign p11 = col1_q[1];
  assign p21 = col1_q[2];
  assign p02 = tap2;
  assign p12 = tap1;
  assign p22 = pix_in;

endmodule

// File: rtl/sobel_edge_detect.sv
// Streaming 3x3 Sobel magnitude: reads the gray frame in raster order and
// writes one saturated gradient magnitude per pixel to the edge BRAM.
// Define SOBEL_THRESHOLD_EN to write 8'hFF/8'h00 against THRESH instead.
module sobel_edge_detect
  import sobel_pkg::*;
#(
  parameter int unsigned LINE_W  = IMG_W,
  parameter int unsigned FRAME_H = IMG_H
) (
  input  logic                i_CLK,
  input  logic                i_RSTn,
  sobel_edge_detect_if.slave  bus
);

  localparam int unsigned NPIX   = LINE_W * FRAME_H;
  localparam int unsigned SHIFTS = NPIX + LINE_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] gray_addr_q, gray_addr_d;
  logic              gray_re_q, gray_re_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] sh_cnt_q, sh_cnt_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] edge_addr_q, edge_addr_d;
  pixel_t            edge_data_q, edge_data_d;
  logic              edge_we_q, edge_we_d;

  logic              shift_en, out_fire, border;
  pixel_t            pix_in, mag_sat, pix_val;
  pixel_t            w00, w01, w02, w10, w11, w12, w20, w21, w22;
  logic [10:0]       sum_r, sum_l, sum_b, sum_t, abs_x, abs_y, mag;
  logic signed [10:0] gx, gy;

  // Real pixels while reads return, zeros during flush until the last center is formed
  always_comb begin
    shift_en = rd_valid_q | ((state_q == FLUSH) && (sh_cnt_q < ADDR_W'(SHIFTS)));
    pix_in   = rd_valid_q ? bus.i_GRAY_DATA : '0;
    out_fire = shift_en && (sh_cnt_q >= ADDR_W'(LINE_W + 1));
    border   = (row_q == '0) || (row_q == ADDR_W'(FRAME_H - 1)) ||
               (col_q == '0) || (col_q == ADDR_W'(LINE_W - 1));
  end

  sobel_window #(.W(LINE_W)) u_window (
    .clk      (i_CLK),
    .rst_n    (i_RSTn),
    .shift_en (shift_en),
    .pix_in   (pix_in),
    .p00 (w00), .p01 (w01), .p02 (w02),
    .p10 (w10), .p11 (w11), .p12 (w12),
    .p20 (w20), .p21 (w21), .p22 (w22)
  );

  // Gradient magnitude |Gx|+|Gy| with 8-bit saturation
  always_comb begin
    sum_r   = 11'(w02) + 11'({w12, 1'b0}) + 11'(w22);
    sum_l   = 11'(w00) + 11'({w10, 1'b0}) + 11'(w20);
    sum_b   = 11'(w20) + 11'({w21, 1'b0}) + 11'(w22);
    sum_t   = 11'(w00) + 11'({w01, 1'b0}) + 11'(w02);
    gx      = $signed(sum_r - sum_l);
    gy      = $signed(sum_b - sum_t);
    abs_x   = gx[10] ? 11'(-gx) : 11'(gx);
    abs_y   = gy[10] ? 11'(-gy) : 11'(gy);
    mag     = abs_x + abs_y;
    mag_sat = (mag > 11'd255) ? 8'hFF : mag[7:0];
`ifdef SOBEL_THRESHOLD_EN
    pix_val = (mag_sat >= 8'(THRESH)) ? 8'hFF : 8'h00;
`else
    pix_val = mag_sat;
`endif
  end

  // FSM next state, read address generation and output-pixel tracking
  always_comb begin
    state_d     = state_q;
    gray_addr_d = gray_addr_q;
    rd_valid_d  = gray_re_q;
    sh_cnt_d    = sh_cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    edge_addr_d = edge_addr_q;
    edge_data_d = edge_data_q;
    edge_we_d   = out_fire;

    if (shift_en) sh_cnt_d = sh_cnt_q + 1'b1;

    if (out_fire) begin
      edge_addr_d = sh_cnt_q - ADDR_W'(LINE_W + 1);
      edge_data_d = border ? 8'h00 : pix_val;
      if (col_q == ADDR_W'(LINE_W - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.i_START) begin
          state_d     = RUN;
          gray_addr_d = '0;
          sh_cnt_d    = '0;
          row_d       = '0;
          col_d       = '0;
        end
      end
      RUN: begin
        if (gray_addr_q == ADDR_W'(NPIX - 1)) state_d = FLUSH;
        else gray_addr_d = gray_addr_q + 1'b1;
      end
      FLUSH: begin
        if (edge_we_q && (edge_addr_q == ADDR_W'(NPIX - 1))) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != RUN) gray_addr_d = '0;
    gray_re_d = (state_d == RUN);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  // State, counters and registered BRAM/status outputs
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q     <= IDLE;
      gray_addr_q <= '0;
      gray_re_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      sh_cnt_q    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      edge_addr_q <= '0;
      edge_data_q <= '0;
      edge_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gray_addr_q <= gray_addr_d;
      gray_re_q   <= gray_re_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      sh_cnt_q    <= sh_cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      edge_addr_q <= edge_addr_d;
      edge_data_q <= edge_data_d;
      edge_we_q   <= edge_we_d;
    end
  end

  assign bus.o_BUSY      = busy_q;
  assign bus.o_DONE      = done_q;
  assign bus.o_GRAY_ADDR = gray_addr_q;
  assign bus.o_GRAY_RE   = gray_re_q;
  assign bus.o_EDGE_ADDR = edge_addr_q;
  assign bus.o_EDGE_DATA = edge_data_q;
  assign bus.o_EDGE_WE   = edge_we_q;

endmodule

// File: doc/sobel_edge_detect.md
# sobel_edge_detect

Streaming 3x3 Sobel edge stage sitting directly downstream of the RGB-to-gray converter. Once the converter signals its gray frame complete, a start pulse makes this block read the 320x240 8-bit gray BRAM in raster order and write one 8-bit gradient magnitude per pixel into a separate edge BRAM. That BRAM is then read back over AXI by the existing address/read-request path. Port muxing of the gray BRAM between this block and AXI, selected by STATE_SELECT, stays outside the block.

## Interface
- IMG_W, 320, pixels per line
- IMG_H, 240, lines per frame
- ADDR_W, 17, BRAM address width (covers IMG_W*IMG_H = 76800)
- THRESH, 128, binarization threshold (used only with SOBEL_THRESHOLD_EN)
- i_CLK  in  1  single clock, all logic on rising edge
- i_RSTn  in  1  asynchronous active-low reset
- i_START  in  1  one-cycle start pulse; ignored while o_BUSY=1
- o_BUSY  out  1  high from the cycle after start until the o_DONE cycle, inclusive
- o_DONE  out  1  one-cycle pulse, frame complete
- o_GRAY_ADDR  out  ADDR_W  gray BRAM read address
- o_GRAY_RE  out  1  gray BRAM read enable
- i_GRAY_DATA  in  8  gray BRAM read data, valid 1 cycle after o_GRAY_RE
- o_EDGE_ADDR  out  ADDR_W  edge BRAM write address
- o_EDGE_DATA  out  8  edge BRAM write data
- o_EDGE_WE  out  1  edge BRAM write enable

## Operation
- FSM: IDLE -> RUN on i_START. RUN -> FLUSH after read address N-1 is issued (N=IMG_W*IMG_H). FLUSH -> DONE after the write of address N-1. DONE -> IDLE unconditionally after 1 cycle.
- RUN: o_GRAY_RE=1 every cycle, o_GRAY_ADDR counts 0..N-1 with one address per cycle and no gaps.
- Each returned pixel shifts into a 3x3 window fed by two IMG_W-deep line buffers. Output index lags input index by IMG_W+1, so the window center is input pixel k-(IMG_W+1).
- FLUSH: shifts zeros in for IMG_W+1 cycles so every output index 0..N-1 is produced. o_GRAY_RE=0.
- Arithmetic:
  - Gx = (p02+2p12+p22)-(p00+2p10+p20) and Gy = (p20+2p21+p22)-(p00+2p01+p02), each 11-bit signed.
  - mag = |Gx|+|Gy|, 11-bit unsigned, max 2040. Saturate to 8 bits: mag>255 gives 255.
- Border: center row 0 or IMG_H-1, or column 0 or IMG_W-1, writes 0. This suppresses line-wrap garbage.
- o_EDGE_WE is high for exactly N cycles, possibly non-contiguous only at the RUN/FLUSH seam. o_EDGE_ADDR ascends 0..N-1 with each address written exactly once.
- i_START while busy: ignored, with no restart and no counter disturbance.
- Reset mid-frame: immediately IDLE, counters cleared. Edge BRAM contents are undefined until the next complete frame.

## Timing
- Reset values:
  - o_BUSY, o_DONE, o_GRAY_RE and o_EDGE_WE are 0.
  - o_GRAY_ADDR, o_EDGE_ADDR and o_EDGE_DATA are 0.
- i_START sampled at cycle 0: o_BUSY=1 and o_GRAY_RE=1 with address 0 at cycle 1.
- Read latency is 1 cycle. Window update is 1 cycle. Magnitude/saturation is registered (1 cycle).
- First o_EDGE_WE (address 0) at cycle IMG_W+4. The write of address N-1 is at cycle N+IMG_W+3.
- o_DONE at cycle N+IMG_W+4, o_BUSY drops the cycle after that, and a new i_START is accepted from that cycle.
- Total frame: N+IMG_W+5 cycles, i.e. 77125 for defaults.

## Configuration
- SOBEL_THRESHOLD_EN defined: o_EDGE_DATA = 8'hFF if saturated mag >= THRESH, else 8'h00. Border pixels are still 0. Latency is unchanged, with the compare in the same registered stage.
- Undefined: o_EDGE_DATA is the saturated magnitude and THRESH is unused.

## Structure
- Package sobel_pkg holds:
  - IMG_W, IMG_H and N constants, plus ADDR_W.
  - the pixel_t (logic [7:0]) typedef.
  - the state enum {IDLE, RUN, FLUSH, DONE}.
- Sub-module sobel_window: two line buffers plus the 3x3 register window with shift enable.
  - Inputs: pixel in and shift enable. Output: nine window pixels.
  - The top level holds the FSM, counters, row/column trackers, gradient math and BRAM ports.

## Test plan
- Constant image 0x80 -> all 76800 writes equal 0, and o_DONE asserts at cycle 77124 after start.
- Vertical step (col<160 = 0, else 255) -> interior columns 159 and 160 equal 255, all others 0.
- Horizontal ramp (pixel = col mod 256) -> interior pixels equal 8 except around the 255->0 wrap at col 256 (saturate 255). Border pixels equal 0.
- Random image -> rows 0/239 and cols 0/319 all 0. Interior matches the reference model bit-exact. Each address is written exactly once in ascending order.
- i_START re-pulsed mid-frame, then i_RSTn low for 2 cycles mid-frame, then restart -> the pulse is ignored, outputs return to reset values, and the second frame is correct.
- With SOBEL_THRESHOLD_EN and THRESH=8 on the ramp -> interior 0xFF, border 0x00. THRESH=9 -> interior 0x00 except the wrap columns.
